pl_instmem: RTL and testbench

PL_INSTMEM -- requirements
Module: pl_instmem

---
 rtl/pl_instmem.sv | 161 ++++++++++++++++
 tb/tb_pl_instmem.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pl_instmem.sv
// ============================================================================
// pl_instmem -- pipelined instruction memory with a load port
//
// A 2^ADDR_W x DATA_W word memory. After reset it zeroes itself one word per
// cycle (busy=1), then serves instruction fetches through a single
// valid/ack output register with one cycle of latency. A separate load port
// writes words while running. A write and a fetch of the same word in one
// cycle return the written data.
//
// Optional feature (compile-time macro PL_INSTMEM_FAULT_EN):
//   defined   -> misaligned fetches (fetch_addr[1:0]!=0) and fetches with any
//                bit above the memory range set report inst_fault=1, inst=0.
//   undefined -> inst_fault is tied to 0 and the address wraps modulo depth.
//
// Ports:
//   clk         in   clock, all state changes on the rising edge
//   clrn        in   asynchronous active-low reset
//   fetch_req   in   fetch request
//   fetch_addr  in   [31:0] byte address, word index = fetch_addr[ADDR_W+1:2]
//   fetch_ready out  a fetch can be accepted this cycle
//   inst        out  [DATA_W-1:0] fetched instruction
//   inst_valid  out  inst / inst_fault are valid
//   inst_fault  out  the held fetch faulted
//   inst_ack    in   consumer takes the current output
//   ld_we       in   load-port write enable
//   ld_addr     in   [ADDR_W-1:0] load-port word address
//   ld_data     in   [DATA_W-1:0] load-port write data
//   busy        out  post-reset clear in progress
// ============================================================================
module pl_instmem #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_ready,
    output logic [DATA_W-1:0] inst,
    output logic              inst_valid,
    output logic              inst_fault,
    input  logic              inst_ack,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_next;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    logic [DATA_W-1:0] r_inst;
    logic              r_valid;
    logic              r_fault;

    logic              w_run;
    logic              w_accept;
    logic              w_fault;
    logic [ADDR_W-1:0] w_fetch_idx;
    logic              w_ld_en;
    logic              w_bypass;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;

    // ------------------------------------------------------------------
    // FSM: CLEAR walks the counter through every word, RUN serves fetches
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        if (r_state == S_CLEAR) begin
            w_clr_cnt_next = r_clr_cnt + 1'b1;
            // Last word is cleared on this edge; RUN starts on the same edge.
            if (r_clr_cnt == ADDR_W'(DEPTH - 1)) begin
                w_state_next   = S_RUN;
                w_clr_cnt_next = '0;
            end
        end
    end

    assign w_run       = (r_state == S_RUN);
    assign busy        = !w_run;
    assign fetch_ready = w_run && (!r_valid || inst_ack);
    assign w_accept    = fetch_req && fetch_ready;
    assign w_fetch_idx = fetch_addr[ADDR_W+1:2];

`ifdef PL_INSTMEM_FAULT_EN
    assign w_fault = (fetch_addr[1:0] != 2'b00) || (|fetch_addr[31:ADDR_W+2]);
`else
    // Alignment and upper address bits are deliberately ignored (address wraps).
    logic w_unused_addr;
    assign w_unused_addr = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0]};
    assign w_fault       = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Memory write port: clear writes in CLEAR, load-port writes in RUN
    // ------------------------------------------------------------------
    assign w_ld_en     = w_run && ld_we;
    assign w_mem_we    = !w_run || ld_we;
    assign w_mem_waddr = w_run ? ld_addr : r_clr_cnt;
    assign w_mem_wdata = w_run ? ld_data : '0;
    assign w_bypass    = w_ld_en && (ld_addr == w_fetch_idx);

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Output register: registered read with valid/ack handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_inst  <= '0;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_fault <= w_fault;
            if (w_fault) begin
                r_inst <= '0;
            end else if (w_bypass) begin
                r_inst <= ld_data;
            end else begin
                r_inst <= r_mem[w_fetch_idx];
            end
        end else if (inst_ack) begin
            // Ack with nothing held simply re-clears an already-clear flag.
            r_valid <= 1'b0;
        end
    end

    assign inst       = r_inst;
    assign inst_valid = r_valid;
    assign inst_fault = r_fault;

endmodule

// File: tb/tb_pl_instmem.sv
module tb_pl_instmem;

    logic        clk = 1'b0;
    logic        clrn;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_fault;
    logic        inst_ack;
    logic        ld_we;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        busy;

    int n_pass = 0;
    int n_total = 0;
    int n_busy;

    always #5 clk = ~clk;

    pl_instmem #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ready(fetch_ready),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_fault (inst_fault),
        .inst_ack   (inst_ack),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
            $display("check %-16s obs=%08h exp=%08h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // advance one rising edge, then settle before sampling / driving
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // release reset on a falling edge, count cycles with busy=1 (bounded)
    task automatic release_and_count(output int n);
        @(negedge clk);
        clrn = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        clrn = 1'b0; fetch_req = 1'b0; fetch_addr = '0; inst_ack = 1'b0;
        ld_we = 1'b0; ld_addr = '0; ld_data = '0;

        // reset state
        repeat (3) step();
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_fault", 32'(inst_fault), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_ready", 32'(fetch_ready), 32'd0);

        // clear length and first fetch
        release_and_count(n_busy);
        check("busy_cycles", 32'(n_busy), 32'd32);
        check("ready_run", 32'(fetch_ready), 32'd1);
        fetch_req = 1'b1; fetch_addr = 32'h0;
        step();
        fetch_req = 1'b0;
        check("f0_valid", 32'(inst_valid), 32'd1);
        check("f0_inst", inst, 32'h0);
        inst_ack = 1'b1;
        step();
        inst_ack = 1'b0;
        check("ack_drop", 32'(inst_valid), 32'd0);

        // ack with nothing held has no effect
        inst_ack = 1'b1;
        step();
        inst_ack = 1'b0;
        check("ack_idle", 32'(inst_valid), 32'd0);

        // load words 0,1,2
        ld_we = 1'b1;
        ld_addr = 5'd0; ld_data = 32'h3c010000; step();
        ld_addr = 5'd1; ld_data = 32'h34240050; step();
        ld_addr = 5'd2; ld_data = 32'h11112222; step();
        ld_we = 1'b0;

        // back-to-back fetches with ack held high
        inst_ack = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h00;
        step();
        check("b2b0_valid", 32'(inst_valid), 32'd1);
        check("b2b0_inst", inst, 32'h3c010000);
        fetch_addr = 32'h04;
        step();
        check("b2b1_valid", 32'(inst_valid), 32'd1);
        check("b2b1_inst", inst, 32'h34240050);
        fetch_req = 1'b0;
        step();
        check("b2b_drain", 32'(inst_valid), 32'd0);
        inst_ack = 1'b0;

        // stall: output held while ack=0, request stays pending
        fetch_req = 1'b1; fetch_addr = 32'h08;
        step();
        fetch_addr = 32'h00;
        for (int i = 0; i < 3; i++) begin
            check("stall_ready", 32'(fetch_ready), 32'd0);
            check("stall_inst", inst, 32'h11112222);
            check("stall_valid", 32'(inst_valid), 32'd1);
            step();
        end
        check("stall_hold", inst, 32'h11112222);
        fetch_addr = 32'h04; inst_ack = 1'b1;
        #1;
        check("unstall_ready", 32'(fetch_ready), 32'd1);
        step();
        check("unstall_inst", inst, 32'h34240050);
        check("unstall_valid", 32'(inst_valid), 32'd1);
        fetch_req = 1'b0;
        step();
        inst_ack = 1'b0;

        // write bypass on same word
        ld_we = 1'b1; ld_addr = 5'd3; ld_data = 32'h0c000018;
        fetch_req = 1'b1; fetch_addr = 32'h0C;
        step();
        ld_we = 1'b0; fetch_req = 1'b0;
        check("bypass_inst", inst, 32'h0c000018);
        inst_ack = 1'b1; step(); inst_ack = 1'b0;
        fetch_req = 1'b1; fetch_addr = 32'h0C;
        step();
        fetch_req = 1'b0;
        check("bypass_mem", inst, 32'h0c000018);
        inst_ack = 1'b1; step(); inst_ack = 1'b0;

        // fault / wrap behaviour
        fetch_req = 1'b1; fetch_addr = 32'h80;
        step();
        fetch_req = 1'b0;
`ifdef PL_INSTMEM_FAULT_EN
        check("a80_fault", 32'(inst_fault), 32'd1);
        check("a80_inst", inst, 32'h0);
`else
        check("a80_fault", 32'(inst_fault), 32'd0);
        check("a80_inst", inst, 32'h3c010000);
`endif
        inst_ack = 1'b1; step(); inst_ack = 1'b0;
        fetch_req = 1'b1; fetch_addr = 32'h06;
        step();
        fetch_req = 1'b0;
`ifdef PL_INSTMEM_FAULT_EN
        check("a06_fault", 32'(inst_fault), 32'd1);
        check("a06_inst", inst, 32'h0);
`else
        check("a06_fault", 32'(inst_fault), 32'd0);
        check("a06_inst", inst, 32'h34240050);
`endif

        // reset with an output pending (no ack): discarded at once
        check("pend_valid", 32'(inst_valid), 32'd1);
        clrn = 1'b0;
        #1;
        check("arst_valid", 32'(inst_valid), 32'd0);
        check("arst_inst", inst, 32'h0);
        check("arst_busy", 32'(busy), 32'd1);

        // reset again at cycle 10 of the clear; clear must restart
        @(negedge clk);
        clrn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        clrn = 1'b0;
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_valid", 32'(inst_valid), 32'd0);
        release_and_count(n_busy);
        check("busy_restart", 32'(n_busy), 32'd32);

        // memory was cleared by the restarted clear
        fetch_req = 1'b1; fetch_addr = 32'h00;
        step();
        fetch_req = 1'b0;
        check("clr_word0", inst, 32'h0);
        check("clr_valid", 32'(inst_valid), 32'd1);
        fetch_req = 1'b1; fetch_addr = 32'h0C; inst_ack = 1'b1;
        step();
        fetch_req = 1'b0; inst_ack = 1'b0;
        check("clr_word3", inst, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
